// File: rtl/gate_tt_checker_if.sv
// Signal bundle between the truth-table checker and whoever drives/observes it.
// Optional first-failure capture signals exist only with GATE_TT_FIRST_FAIL_EN.
interface gate_tt_checker_if #(
  parameter int ERR_CNT_W = 4
);
  logic                 start;
  logic [7:0]           gate_out;
  logic                 a_drv;
  logic                 b_drv;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [ERR_CNT_W-1:0] err_count;
  logic [7:0]           fail_mask;
`ifdef GATE_TT_FIRST_FAIL_EN
  logic                 first_fail_vld;
  logic [1:0]           first_fail_vec;
  logic [7:0]           first_fail_bits;

  modport master (
    output start, gate_out,
    input  a_drv, b_drv, busy, done, pass, err_count, fail_mask,
    input  first_fail_vld, first_fail_vec, first_fail_bits
  );
  modport slave (
    input  start, gate_out,
    output a_drv, b_drv, busy, done, pass, err_count, fail_mask,
    output first_fail_vld, first_fail_vec, first_fail_bits
  );
`else
  modport master (
    output start, gate_out,
    input  a_drv, b_drv, busy, done, pass, err_count, fail_mask
  );
  modport slave (
    input  start, gate_out,
    output a_drv, b_drv, busy, done, pass, err_count, fail_mask
  );
`endif
endinterface

// File: rtl/gate_tt_checker.sv
// Drives all four {A,B} vectors into the basic-gate block and checks its eight outputs.
// Define GATE_TT_FIRST_FAIL_EN to add capture of the first failing vector.
module gate_tt_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_CNT_W     = 4
) (
  input logic              clk,
  input logic              rst_n,
  gate_tt_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam int                   CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam int                   SUM_W    = ERR_CNT_W + 4;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("gate_tt_checker: SETTLE_CYCLES must be >= 1");
  end

  state_t               state_q, state_nxt;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic                 a_q, a_nxt, b_q, b_nxt;
  logic [ERR_CNT_W-1:0] err_q, err_nxt;
  logic [7:0]           mask_q, mask_nxt;
  logic                 pass_q, pass_nxt;
  logic [7:0]           exp_vec, mism;
  logic [SUM_W-1:0]     err_sum;
  logic [ERR_CNT_W-1:0] err_sat;
`ifdef GATE_TT_FIRST_FAIL_EN
  logic                 ff_vld_q, ff_vld_nxt;
  logic [1:0]           ff_vec_q, ff_vec_nxt;
  logic [7:0]           ff_bits_q, ff_bits_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      err_q     <= '0;
      mask_q    <= '0;
      pass_q    <= 1'b0;
`ifdef GATE_TT_FIRST_FAIL_EN
      ff_vld_q  <= 1'b0;
      ff_vec_q  <= '0;
      ff_bits_q <= '0;
`endif
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      a_q       <= a_nxt;
      b_q       <= b_nxt;
      err_q     <= err_nxt;
      mask_q    <= mask_nxt;
      pass_q    <= pass_nxt;
`ifdef GATE_TT_FIRST_FAIL_EN
      ff_vld_q  <= ff_vld_nxt;
      ff_vec_q  <= ff_vec_nxt;
      ff_bits_q <= ff_bits_nxt;
`endif
    end
  end

  // The current drive bits double as the vector index; the sum is widened so saturation never wraps
  always_comb begin
    exp_vec = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q), ~b_q, ~a_q, a_q | b_q, a_q & b_q};
    mism    = bus.gate_out ^ exp_vec;
    err_sum = {4'b0, err_q} + SUM_W'($countones(mism));
    err_sat = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_CNT_W-1:0];
  end

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    a_nxt       = a_q;
    b_nxt       = b_q;
    err_nxt     = err_q;
    mask_nxt    = mask_q;
    pass_nxt    = pass_q;
`ifdef GATE_TT_FIRST_FAIL_EN
    ff_vld_nxt  = ff_vld_q;
    ff_vec_nxt  = ff_vec_q;
    ff_bits_nxt = ff_bits_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_nxt   = SETTLE;
          cnt_nxt     = CNT_LOAD;
          a_nxt       = 1'b0;
          b_nxt       = 1'b0;
          err_nxt     = '0;
          mask_nxt    = '0;
          pass_nxt    = 1'b0;
`ifdef GATE_TT_FIRST_FAIL_EN
          ff_vld_nxt  = 1'b0;
          ff_vec_nxt  = '0;
          ff_bits_nxt = '0;
`endif
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_nxt = SAMPLE;
        else             cnt_nxt   = cnt_q - 1'b1;
      end
      SAMPLE: begin
        mask_nxt = mask_q | mism;
        err_nxt  = err_sat;
`ifdef GATE_TT_FIRST_FAIL_EN
        if (!ff_vld_q && (mism != 8'h00)) begin
          ff_vld_nxt  = 1'b1;
          ff_vec_nxt  = {a_q, b_q};
          ff_bits_nxt = mism;
        end
`endif
        if ({a_q, b_q} != 2'b11) begin
          {a_nxt, b_nxt} = {a_q, b_q} + 2'b01;
          cnt_nxt        = CNT_LOAD;
          state_nxt      = SETTLE;
        end else begin
          a_nxt     = 1'b0;
          b_nxt     = 1'b0;
          pass_nxt  = (err_sat == '0);
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.a_drv     = a_q;
  assign bus.b_drv     = b_q;
  assign bus.busy      = (state_q == SETTLE) || (state_q == SAMPLE);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_mask = mask_q;
`ifdef GATE_TT_FIRST_FAIL_EN
  assign bus.first_fail_vld  = ff_vld_q;
  assign bus.first_fail_vec  = ff_vec_q;
  assign bus.first_fail_bits = ff_bits_q;
`endif

endmodule

// File: doc/gate_tt_checker.md
Name: gate_tt_checker

Overview:
- Self-checking driver and monitor for the two-input basic-gate block.
- Drives each of the four {A,B} input combinations onto the gate block's A/B inputs.
- After a programmable settle time, samples the gate block's eight outputs and compares them against an internally computed truth table.
- Accumulates an error count and a per-gate failure mask, then reports pass/fail with a start/done handshake.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range >=1 (elaboration-time error if 0)
ERR_CNT_W, 4, width of err_count; counter saturates at 2^ERR_CNT_W-1

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a check run; accepted only in IDLE
gate_out  input  8  gate block outputs: bit0 AND, 1 OR, 2 NOT_A, 3 NOT_B, 4 NAND, 5 NOR, 6 XOR, 7 XNOR
a_drv  output  1  drives gate block input A
b_drv  output  1  drives gate block input B
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse when results are final
pass  output  1  1 when last completed run had err_count==0
err_count  output  ERR_CNT_W  total mismatching bits over the run, saturating
fail_mask  output  8  sticky per-gate mismatch flags for the run

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values (all outputs): a_drv=0, b_drv=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0. FSM goes to IDLE, vector index=0, settle counter=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 at an edge: go to SETTLE; vector idx=0 ({a_drv,b_drv}=00); busy=1; err_count, fail_mask and pass cleared; settle counter loaded with SETTLE_CYCLES-1.
  - start=0: stay in IDLE. Results hold their last values.
- SETTLE: decrement the counter each cycle; at 0, go to SAMPLE. a_drv/b_drv are stable throughout.
- SAMPLE (one cycle):
  - Expected vector: exp = {~(A^B), A^B, ~(A|B), ~(A&B), ~B, ~A, A|B, A&B}, using the current a_drv/b_drv.
  - mism = gate_out ^ exp.
  - fail_mask |= mism.
  - err_count += popcount(mism), saturating at max. No wrap.
  - If idx<3: idx++, update a_drv/b_drv to {a,b}=idx (order 00,01,10,11), reload the counter, go to SETTLE.
  - If idx==3: go to DONE.
- DONE (one cycle): done=1, busy=0, pass=(err_count==0) using the final accumulated count. a_drv/b_drv return to 0. Next state is IDLE.
- Latency: start accepted at edge k → busy=1 from cycle k+1; done=1 in cycle k+1+4*(SETTLE_CYCLES+1). With the default, that is k+13.
- Boundary conditions:
  - start is ignored while busy and during DONE. It must be reasserted in IDLE.
  - start held high continuously: a new run begins the cycle after DONE.
  - Saturation: worst case is 32 mismatches. With ERR_CNT_W=4, err_count saturates at 15 and stays there.
  - Reset mid-run: everything returns to reset values immediately; no done pulse is produced.
  - Only gate_out in the SAMPLE cycle is observed; glitches during SETTLE are ignored.
- pass, err_count and fail_mask are stable from DONE until the next accepted start.

Optional Feature:
GATE_TT_FIRST_FAIL_EN
- Defined: adds three outputs:
  - first_fail_vld (1 bit)
  - first_fail_vec (2 bits, {A,B})
  - first_fail_bits (8 bits)
- Capture: on the first SAMPLE cycle of a run with mism!=0, latch vld=1, the current vector and mism. Later failures do not overwrite the capture.
- Clearing: the three outputs clear on reset and on an accepted start.
- Not defined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Correct gate model connected, start pulse at cycle 5 → done at cycle 18; pass=1, err_count=0, fail_mask=8'h00.
- XOR output stuck-at-0 → mismatches at vectors 01 and 10; err_count=2, fail_mask=8'h40, pass=0. With FIRST_FAIL_EN: first_fail_vec=2'b01, first_fail_bits=8'h40.
- All eight outputs inverted → 32 mismatches; err_count=15 (saturated), fail_mask=8'hFF, pass=0.
- Monitor a_drv/b_drv during a run → sequence 00,01,10,11, each held exactly SETTLE_CYCLES+1 cycles; with SETTLE_CYCLES=1, done arrives 9 cycles after start is accepted.
- start pulsed mid-run and again during DONE → both ignored, exactly one done pulse. start asserted the cycle after DONE → a new run begins and results are cleared.
- rst_n low during SAMPLE of vector 10 → all outputs return to 0 asynchronously, no done pulse. After release, a run with a correct model passes.
